// File: rtl/fft_bin_collector.sv
// Frames the tiny_fft serial stream (real word then imaginary word per bin), stores
// per-bin L1 magnitudes, tracks the peak bin and drains one frame to a valid/ready host.
module fft_bin_collector #(
    parameter int unsigned N_BINS = 8,
    parameter int unsigned DW     = 6,
    parameter int unsigned MW     = DW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DW-1:0]             fft_data,
    input  logic                      fft_real,
    input  logic                      fft_idx_zero,
    output logic                      mag_valid,
    input  logic                      mag_ready,
    output logic [MW-1:0]             mag_data,
    output logic [$clog2(N_BINS)-1:0] mag_idx,
    output logic                      mag_last,
    output logic [$clog2(N_BINS)-1:0] peak_idx,
    output logic [MW-1:0]             peak_mag,
    output logic                      busy,
    output logic                      sync_err
);

    localparam int unsigned BW = $clog2(N_BINS);
    localparam logic [BW-1:0] LAST_BIN = BW'(N_BINS - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_COL_RE = 2'd1,
        ST_COL_IM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          frame_start_c;
    logic          frame_err_c;
    logic [DW-1:0] re_q, re_d;
    logic [BW-1:0] bin_q, bin_d;
    logic [MW-1:0] mem_q [N_BINS];
    logic          mem_we_c;

    logic          mag_valid_q, mag_valid_d;
    logic [MW-1:0] mag_data_q, mag_data_d;
    logic [BW-1:0] mag_idx_q, mag_idx_d;
    logic          mag_last_q, mag_last_d;
    logic [BW-1:0] peak_idx_q, peak_idx_d;
    logic [MW-1:0] peak_mag_q, peak_mag_d;
    logic          sync_err_q, sync_err_d;
    logic          busy_q, busy_d;
    logic [BW-1:0] nxt_idx_c;

    logic signed [MW-1:0] re_sx_c, im_sx_c;
    logic [MW-1:0]        re_abs_c, im_abs_c, mag_c;

    // L1 magnitude of the held real word and the current imaginary word; MW bits never overflow
    always_comb begin
        re_sx_c  = MW'(signed'(re_q));
        im_sx_c  = MW'(signed'(fft_data));
        re_abs_c = re_sx_c[MW-1] ? MW'(-re_sx_c) : MW'(re_sx_c);
        im_abs_c = im_sx_c[MW-1] ? MW'(-im_sx_c) : MW'(im_sx_c);
        mag_c    = re_abs_c + im_abs_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing: HUNT waits for a bin-0 real word; COLLECT alternates real/imaginary words
    always_comb begin
        state_d       = state_q;
        frame_start_c = 1'b0;
        frame_err_c   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (fft_real && fft_idx_zero) begin
                    frame_start_c = 1'b1;
                    state_d       = ST_COL_IM;
                end
            end
            ST_COL_RE: begin
                if (!fft_real || fft_idx_zero) begin
                    frame_err_c = 1'b1;
                    state_d     = ST_HUNT;
                end else begin
                    state_d = ST_COL_IM;
                end
            end
            ST_COL_IM: begin
                if (fft_real) begin
                    frame_err_c = 1'b1;
                    state_d     = ST_HUNT;
                end else if (bin_q == LAST_BIN) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_COL_RE;
                end
            end
            ST_DRAIN: begin
                if (mag_valid_q && mag_ready && mag_last_q) begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        re_d        = re_q;
        bin_d       = bin_q;
        mem_we_c    = 1'b0;
        mag_valid_d = mag_valid_q;
        mag_data_d  = mag_data_q;
        mag_idx_d   = mag_idx_q;
        mag_last_d  = mag_last_q;
        peak_idx_d  = peak_idx_q;
        peak_mag_d  = peak_mag_q;
        sync_err_d  = frame_err_c;
        busy_d      = (state_d != ST_HUNT);
        nxt_idx_c   = mag_idx_q + BW'(1);
        case (state_q)
            ST_HUNT: begin
                if (frame_start_c) begin
                    re_d       = fft_data;
                    bin_d      = '0;
                    peak_idx_d = '0;
                    peak_mag_d = '0;
                end
            end
            ST_COL_RE: begin
                if (!frame_err_c) begin
                    re_d = fft_data;
                end
            end
            ST_COL_IM: begin
                if (!frame_err_c) begin
                    mem_we_c = 1'b1;
                    // Strict compare keeps the lower bin on ties
                    if ((bin_q == '0) || (mag_c > peak_mag_q)) begin
                        peak_mag_d = mag_c;
                        peak_idx_d = bin_q;
                    end
                    if (bin_q == LAST_BIN) begin
                        mag_valid_d = 1'b1;
                        mag_data_d  = mem_q[0];
                        mag_idx_d   = '0;
                        mag_last_d  = 1'b0;
                    end else begin
                        bin_d = bin_q + BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (mag_valid_q && mag_ready) begin
                    if (mag_last_q) begin
                        mag_valid_d = 1'b0;
                        mag_data_d  = '0;
                        mag_idx_d   = '0;
                        mag_last_d  = 1'b0;
                    end else begin
                        mag_idx_d  = nxt_idx_c;
                        mag_data_d = mem_q[nxt_idx_c];
                        mag_last_d = (nxt_idx_c == LAST_BIN);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q        <= '0;
            bin_q       <= '0;
            mag_valid_q <= 1'b0;
            mag_data_q  <= '0;
            mag_idx_q   <= '0;
            mag_last_q  <= 1'b0;
            peak_idx_q  <= '0;
            peak_mag_q  <= '0;
            sync_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            re_q        <= re_d;
            bin_q       <= bin_d;
            mag_valid_q <= mag_valid_d;
            mag_data_q  <= mag_data_d;
            mag_idx_q   <= mag_idx_d;
            mag_last_q  <= mag_last_d;
            peak_idx_q  <= peak_idx_d;
            peak_mag_q  <= peak_mag_d;
            sync_err_q  <= sync_err_d;
            busy_q      <= busy_d;
        end
    end

    // Frame buffer needs no reset: every entry is rewritten before it is drained
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[bin_q] <= mag_c;
        end
    end

    assign mag_valid = mag_valid_q;
    assign mag_data  = mag_data_q;
    assign mag_idx   = mag_idx_q;
    assign mag_last  = mag_last_q;
    assign peak_idx  = peak_idx_q;
    assign peak_mag  = peak_mag_q;
    assign busy      = busy_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_bin_collector.sv
// Directed bench for fft_bin_collector: framing, magnitudes, peak tracking, drain
// backpressure, framing errors and reset aborts against hand-computed values.
module tb_fft_bin_collector;

    localparam int unsigned N_BINS = 8;
    localparam int unsigned DW     = 6;
    localparam int unsigned MW     = 7;
    localparam int unsigned BW     = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fft_data;
    logic          fft_real;
    logic          fft_idx_zero;
    logic          mag_valid;
    logic          mag_ready;
    logic [MW-1:0] mag_data;
    logic [BW-1:0] mag_idx;
    logic          mag_last;
    logic [BW-1:0] peak_idx;
    logic [MW-1:0] peak_mag;
    logic          busy;
    logic          sync_err;

    int n_vec = 0;
    int n_err = 0;

    int re_tab  [2][N_BINS] = '{'{0, 3, -32, 5, 31, 1, 0, 2},
                                '{1, -5, 10, 0, -19, 20, -3, 4}};
    int im_tab  [2][N_BINS] = '{'{0, -4, 0, 5, -32, 1, -1, 2},
                                '{2, 5, -10, 7, 0, 0, -3, -15}};
    int exp_mag [2][N_BINS] = '{'{0, 7, 32, 10, 63, 2, 1, 4},
                                '{3, 10, 20, 7, 19, 20, 6, 19}};

    fft_bin_collector #(.N_BINS(N_BINS), .DW(DW), .MW(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fft_data     (fft_data),
        .fft_real     (fft_real),
        .fft_idx_zero (fft_idx_zero),
        .mag_valid    (mag_valid),
        .mag_ready    (mag_ready),
        .mag_data     (mag_data),
        .mag_idx      (mag_idx),
        .mag_last     (mag_last),
        .peak_idx     (peak_idx),
        .peak_mag     (peak_mag),
        .busy         (busy),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_word(input int d, input logic r, input logic z);
        fft_data     = DW'(d);
        fft_real     = r;
        fft_idx_zero = z;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send_word(0, 1'b0, 1'b0);
    endtask

    task automatic send_bin(input int f, input int b);
        send_word(re_tab[f][b], 1'b1, b == 0);
        send_word(im_tab[f][b], 1'b0, b == 0);
    endtask

    task automatic send_frame(input int f);
        for (int b = 0; b < int'(N_BINS); b++) send_bin(f, b);
    endtask

    // Drain frame f with ready pattern pat; optionally stream frame feed_f meanwhile
    task automatic drain(input int f, input logic [31:0] pat, input int feed_f);
        int  k;
        int  cyc;
        int  w;
        logic rdy;
        k   = 0;
        cyc = 0;
        while (k < int'(N_BINS) && cyc < 64) begin
            rdy       = pat[cyc % 32];
            mag_ready = rdy;
            if (feed_f >= 0 && cyc < 2 * int'(N_BINS)) begin
                w            = cyc;
                fft_real     = (w % 2 == 0);
                fft_data     = DW'((w % 2 == 0) ? re_tab[feed_f][w / 2] : im_tab[feed_f][w / 2]);
                fft_idx_zero = (w / 2 == 0);
            end else begin
                fft_data     = '0;
                fft_real     = 1'b0;
                fft_idx_zero = 1'b0;
            end
            chk("drain_valid", mag_valid, 1);
            chk("drain_idx", mag_idx, k);
            chk("drain_data", mag_data, exp_mag[f][k]);
            chk("drain_last", mag_last, k == int'(N_BINS) - 1);
            chk("drain_no_sync_err", sync_err, 0);
            if (rdy) k++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_xfer_count", k, N_BINS);
        mag_ready    = 1'b0;
        fft_real     = 1'b0;
        fft_idx_zero = 1'b0;
        chk("post_drain_valid", mag_valid, 0);
        chk("post_drain_busy", busy, 0);
        chk("post_drain_sync_err", sync_err, 0);
    endtask

    initial begin
        rst          = 1'b1;
        fft_data     = '0;
        fft_real     = 1'b0;
        fft_idx_zero = 1'b0;
        mag_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", mag_valid, 0);
        chk("rst_data", mag_data, 0);
        chk("rst_idx", mag_idx, 0);
        chk("rst_last", mag_last, 0);
        chk("rst_peak_idx", peak_idx, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_err", sync_err, 0);
        rst = 1'b0;
        idle();

        // Basic frame, host always ready
        send_frame(0);
        chk("f0_busy", busy, 1);
        chk("f0_peak_idx", peak_idx, 4);
        chk("f0_peak_mag", peak_mag, 63);
        drain(0, 32'hFFFF_FFFF, -1);

        // Tie between bins 2 and 5 keeps the lower index
        send_frame(1);
        chk("tie_peak_idx", peak_idx, 2);
        chk("tie_peak_mag", peak_mag, 20);

        // Backpressure drain while a second frame streams in and is dropped
        drain(1, 32'hA5C3_96E1, 0);
        chk("dropped_peak_idx", peak_idx, 2);
        chk("dropped_peak_mag", peak_mag, 20);
        idle();
        chk("dropped_valid", mag_valid, 0);
        chk("dropped_busy", busy, 0);

        // Two consecutive real words at bin 3
        for (int b = 0; b < 3; b++) send_bin(0, b);
        send_word(5, 1'b1, 1'b0);
        chk("pre_err_busy", busy, 1);
        send_word(7, 1'b1, 1'b0);
        chk("err_pulse", sync_err, 1);
        chk("err_busy", busy, 0);
        chk("err_valid", mag_valid, 0);
        idle();
        chk("err_pulse_end", sync_err, 0);
        chk("err_valid_after", mag_valid, 0);
        send_frame(0);
        chk("err_recover_peak", peak_idx, 4);
        drain(0, 32'hFFFF_FFFF, -1);

        // Imaginary word while a real word is expected
        send_bin(1, 0);
        send_word(3, 1'b0, 1'b0);
        chk("im_err_pulse", sync_err, 1);
        chk("im_err_busy", busy, 0);

        // Bin-0 marker on a real word mid-frame
        send_bin(1, 0);
        send_bin(1, 1);
        send_word(4, 1'b1, 1'b1);
        chk("idx0_err_pulse", sync_err, 1);
        chk("idx0_err_busy", busy, 0);
        idle();

        // Reset during COLLECT at bin 5
        for (int b = 0; b < 5; b++) send_bin(0, b);
        send_word(re_tab[0][5], 1'b1, 1'b0);
        chk("col_peak_before_rst", peak_mag, 63);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("col_rst_valid", mag_valid, 0);
        chk("col_rst_busy", busy, 0);
        chk("col_rst_peak_mag", peak_mag, 0);
        send_frame(1);
        chk("col_rst_peak_idx", peak_idx, 2);
        drain(1, 32'hFFFF_FFFF, -1);

        // Reset during DRAIN after three transfers
        send_frame(0);
        mag_ready = 1'b1;
        repeat (3) idle();
        chk("drn_idx_before_rst", mag_idx, 3);
        chk("drn_data_before_rst", mag_data, 10);
        rst = 1'b1;
        idle();
        rst       = 1'b0;
        mag_ready = 1'b0;
        chk("drn_rst_valid", mag_valid, 0);
        chk("drn_rst_busy", busy, 0);
        chk("drn_rst_peak_mag", peak_mag, 0);
        chk("drn_rst_last", mag_last, 0);
        send_frame(1);
        drain(1, 32'h6DB6_DB6D, -1);

        // Stream joins mid-frame: nothing captured until the bin-0 real word
        for (int b = 4; b < int'(N_BINS); b++) begin
            send_word(re_tab[0][b], 1'b1, 1'b0);
            send_word(im_tab[0][b], 1'b0, 1'b0);
            chk("midframe_busy", busy, 0);
        end
        chk("midframe_sync_err", sync_err, 0);
        send_frame(0);
        chk("midframe_peak_idx", peak_idx, 4);
        chk("midframe_peak_mag", peak_mag, 63);
        drain(0, 32'hFFFF_FFFF, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
